// File: rtl/list_free_pkg.sv
// Shared word encoding for the linked-cell heap: tag bits, reserved values,
// and the predicate deciding whether a pointer names a reclaimable cell.
// Imported by list_free; no ports.
package list_free_pkg;

  // Tag bits of a 16-bit heap word.
  localparam logic [15:0] DIR_TAG = 16'h8000;  // direct value (fixnum)
  localparam logic [15:0] MUT_TAG = 16'h4000;  // mutable RAM cell
  localparam logic [15:0] OPQ_TAG = 16'h2000;  // opaque
  localparam logic [15:0] VLT_TAG = 16'h1000;  // volatile

  // Reserved constant words.
  localparam logic [15:0] UNDEF = 16'h0000;
  localparam logic [15:0] NIL   = 16'h0001;
  localparam logic [15:0] FALSE = 16'h0002;
  localparam logic [15:0] TRUE  = 16'h0003;
  localparam logic [15:0] UNIT  = 16'h0004;
  localparam logic [15:0] ZERO  = 16'h8000;  // fixnum 0

  // An indirect pointer into mutable RAM is the only thing we may free.
  // Fixnums, ROM pointers and every reserved constant terminate a chain.
  function automatic logic is_freeable(input logic [15:0] p);
    return (p & (DIR_TAG | MUT_TAG)) == MUT_TAG;
  endfunction

endpackage

// File: rtl/list_free.sv
// Walks a singly-linked chain of one-word cells from a head pointer, freeing each.
// Latency: 2 cycles per freed cell; done pulses 2N+1 cycles after start is sampled.
// Backpressure: none; one request per cycle, allocator error aborts the walk.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start, i_head       start request (IDLE only) and chain head pointer
//   o_busy, o_done        walk in progress / one-cycle normal-completion pulse
//   o_count               cells freed by the last walk, held until next start
//   o_fail                sticky abort flag, cleared by the next accepted start
//   o_rd, o_raddr, i_rdata   allocator read port (data returns one cycle later)
//   o_free, o_addr        allocator free port
//   i_err                 allocator error, aborts the walk from any state
//
// Build option: define LIST_FREE_LIMIT_EN to bound the walk at MAX_CELLS
// frees; otherwise the walk is unbounded and the counter wraps.
module list_free
  import list_free_pkg::*;
#(
  parameter int DATA_SZ   = 16,
  parameter int CNT_SZ    = 8,
  parameter int MAX_CELLS = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [DATA_SZ-1:0] i_head,
  output logic               o_busy,
  output logic               o_done,
  output logic [CNT_SZ-1:0]  o_count,
  output logic               o_fail,
  output logic               o_rd,
  output logic [DATA_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata,
  output logic               o_free,
  output logic [DATA_SZ-1:0] o_addr,
  input  logic               i_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    FREE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_SZ-1:0] cur_q, cur_d;
  logic [CNT_SZ-1:0]  count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               rd_q, rd_d;
  logic [DATA_SZ-1:0] raddr_q, raddr_d;
  logic               free_q, free_d;
  logic [DATA_SZ-1:0] addr_q, addr_d;

  logic               head_ok;
  logic               nxt_ok;
  logic [CNT_SZ-1:0]  count_inc;
  logic               limit_hit;

  assign head_ok   = is_freeable(i_head);
  // i_rdata is the word fetched by the READ issued one cycle before FREE.
  assign nxt_ok    = is_freeable(i_rdata);
  assign count_inc = count_q + 1'b1;

`ifdef LIST_FREE_LIMIT_EN
  // Stop once this free brings the total to MAX_CELLS and the chain goes on.
  assign limit_hit = (count_inc == CNT_SZ'(MAX_CELLS));
`else
  assign limit_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_start && head_ok) state_d = READ;
      READ: state_d = FREE;
      FREE: state_d = (nxt_ok && !limit_hit) ? READ : IDLE;
      default: state_d = IDLE;
    endcase
    // An allocator error kills the walk wherever it is.
    if (i_err) state_d = IDLE;
  end

  // ---------------------------------------------------------------------
  // Output / datapath next values. Request strobes are derived from the
  // state being entered so they appear registered, exactly one cycle long,
  // and aligned with that state.
  // ---------------------------------------------------------------------
  always_comb begin
    cur_d   = cur_q;
    count_d = count_q;
    fail_d  = fail_q;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    free_d  = 1'b0;
    raddr_d = raddr_q;
    addr_d  = addr_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          count_d = '0;
          cur_d   = i_head;
          fail_d  = 1'b0;
          // Nothing to free: finish straight away with a zero count.
          if (!head_ok) done_d = 1'b1;
        end
      end
      READ: ;
      FREE: begin
        count_d = count_inc;
        cur_d   = i_rdata;
        if (!nxt_ok) begin
          done_d = 1'b1;
        end else if (limit_hit) begin
          fail_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_d == READ) begin
      rd_d    = 1'b1;
      raddr_d = cur_d;
    end
    if (state_d == FREE) begin
      free_d = 1'b1;
      addr_d = cur_d;
    end

    // Error: abandon without counting the in-flight cell and without done.
    if (i_err) begin
      cur_d   = cur_q;
      count_d = count_q;
      fail_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_q   <= DATA_SZ'(UNDEF);
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      rd_q    <= 1'b0;
      raddr_q <= DATA_SZ'(UNDEF);
      free_q  <= 1'b0;
      addr_q  <= DATA_SZ'(UNDEF);
    end else begin
      cur_q   <= cur_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      rd_q    <= rd_d;
      raddr_q <= raddr_d;
      free_q  <= free_d;
      addr_q  <= addr_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_count = count_q;
  assign o_fail  = fail_q;
  assign o_rd    = rd_q;
  assign o_raddr = raddr_q;
  assign o_free  = free_q;
  assign o_addr  = addr_q;

endmodule

// File: tb/tb_list_free.sv
// Bench for list_free: table of chain walks plus hand-written error,
// start-while-busy, async reset and (with LIST_FREE_LIMIT_EN) limit sequences.
module tb_list_free;
  import list_free_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_head = 16'h0000;
  logic        o_busy, o_done, o_fail, o_rd, o_free;
  logic [7:0]  o_count;
  logic [15:0] o_raddr, o_addr;
  logic [15:0] i_rdata;
  logic        i_err = 1'b0;

  always #5 i_clk = ~i_clk;

  list_free #(.DATA_SZ(16), .CNT_SZ(8), .MAX_CELLS(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_head(i_head),
    .o_busy(o_busy), .o_done(o_done), .o_count(o_count), .o_fail(o_fail),
    .o_rd(o_rd), .o_raddr(o_raddr), .i_rdata(i_rdata),
    .o_free(o_free), .o_addr(o_addr), .i_err(i_err)
  );

  // Allocator responder: read data one cycle after o_rd, LIFO free-list.
  logic [15:0] mem [0:15];
  logic [15:0] rdata_q = 16'h0000;
  logic [15:0] fl[$];
  int          overlap = 0;
  assign i_rdata = rdata_q;

  always @(posedge i_clk) begin
    if (o_rd) rdata_q <= mem[o_raddr[3:0]];
    if (o_free) fl.push_back(o_addr);
  end
  always @(negedge i_clk) if (o_rd && o_free) overlap++;

  int errors = 0;
  int checks = 0;
  logic [15:0] tr_rd[$];
  logic [15:0] tr_fr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] head);
    @(negedge i_clk);
    i_start = 1'b1;
    i_head  = head;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  // Cycle k = the k-th negedge after the sampling edge.
  task automatic watch(input int budget, output int cyc, output bit done_seen, output bit fail_seen);
    cyc = 0; done_seen = 0; fail_seen = 0;
    tr_rd.delete(); tr_fr.delete();
    for (int k = 1; k <= budget; k++) begin
      @(negedge i_clk);
      if (o_rd) tr_rd.push_back(o_raddr);
      if (o_free) tr_fr.push_back(o_addr);
      if (o_done) begin done_seen = 1; cyc = k; break; end
      if (o_fail) begin fail_seen = 1; cyc = k; break; end
    end
  endtask

  typedef struct {
    logic [15:0]      head;
    int               n;
    logic [2:0][15:0] fr;
    int               cyc;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] head, input int n, input logic [15:0] a0,
                              input logic [15:0] a1, input logic [15:0] a2, input int cyc);
    vec_t v;
    v.head = head; v.n = n; v.fr[0] = a0; v.fr[1] = a1; v.fr[2] = a2; v.cyc = cyc;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    int cyc;
    bit dn, fl_seen;
    int extra;

    for (int a = 0; a < 16; a++) mem[a] = UNDEF;
    mem[0] = NIL;        // 5000 -> NIL
    mem[1] = 16'h5000;   // 5001 -> 5000
    mem[2] = 16'h5001;   // 5002 -> 5001
    mem[4] = ZERO;       // 5004 -> fixnum 0
    mem[5] = 16'h5006;   // 5005 -> 5006
    mem[6] = UNDEF;      // 5006 -> UNDEF
    mem[7] = 16'h5008;   // 5007 <-> 5008 cycle
    mem[8] = 16'h5007;

    vecs[0] = mk(16'h5000, 1, 16'h5000, 16'h0, 16'h0, 3);
    vecs[1] = mk(16'h5002, 3, 16'h5002, 16'h5001, 16'h5000, 7);
    vecs[2] = mk(NIL,      0, 16'h0, 16'h0, 16'h0, 1);
    vecs[3] = mk(16'h8005, 0, 16'h0, 16'h0, 16'h0, 1);
    vecs[4] = mk(16'h0100, 0, 16'h0, 16'h0, 16'h0, 1);
    vecs[5] = mk(16'h5004, 1, 16'h5004, 16'h0, 16'h0, 3);
    vecs[6] = mk(16'h5005, 2, 16'h5005, 16'h5006, 16'h0, 5);

    // Reset state
    #12;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_fail", o_fail, 0);
    check("rst_rd", o_rd, 0);
    check("rst_free", o_free, 0);
    check("rst_count", o_count, 0);
    check("rst_raddr", o_raddr, 16'h0000);
    check("rst_addr", o_addr, 16'h0000);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Table-driven walks
    for (int v = 0; v < 7; v++) begin
      do_start(vecs[v].head);
      watch(40, cyc, dn, fl_seen);
      check($sformatf("v%0d_done", v), dn, 1);
      check($sformatf("v%0d_cyc", v), cyc, vecs[v].cyc);
      check($sformatf("v%0d_count", v), o_count, vecs[v].n);
      check($sformatf("v%0d_fail", v), o_fail, 0);
      check($sformatf("v%0d_busy", v), o_busy, 0);
      check($sformatf("v%0d_nfree", v), tr_fr.size(), vecs[v].n);
      check($sformatf("v%0d_nrd", v), tr_rd.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n; i++) begin
        check($sformatf("v%0d_free%0d", v, i), tr_fr[i], vecs[v].fr[i]);
        check($sformatf("v%0d_rd%0d", v, i), tr_rd[i], vecs[v].fr[i]);
      end
    end

    // Freed cells land on the free-list; the next alloc reuses 5000.
    fl.delete();
    do_start(16'h5002);
    watch(40, cyc, dn, fl_seen);
    check("fl_size", fl.size(), 3);
    check("fl_alloc", fl.pop_back(), 16'h5000);

    // Allocator error during the second cell's READ
    fl.delete();
    do_start(16'h5002);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_err = 1'b1;
    @(negedge i_clk);
    check("err_rd_cell2", o_rd, 1);
    check("err_raddr_cell2", o_raddr, 16'h5001);
    @(posedge i_clk);
    #1 i_err = 1'b0;
    @(negedge i_clk);
    check("err_busy", o_busy, 0);
    check("err_fail", o_fail, 1);
    check("err_done", o_done, 0);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_rd || o_free || o_done) extra++;
    end
    check("err_no_reqs", extra, 0);
    check("err_fail_sticky", o_fail, 1);
    check("err_nfreed", fl.size(), 1);
    do_start(NIL);
    @(negedge i_clk);
    check("err_fail_cleared", o_fail, 0);
    check("err_restart_done", o_done, 1);
    check("err_restart_count", o_count, 0);

    // Start while busy is ignored
    do_start(16'h5002);
    @(posedge i_clk);
    #1 begin i_start = 1'b1; i_head = NIL; end
    @(posedge i_clk);
    #1 i_start = 1'b0;
    watch(40, cyc, dn, fl_seen);
    check("busy_start_done", dn, 1);
    check("busy_start_cyc", cyc, 5);
    check("busy_start_count", o_count, 3);

    // Async reset mid-walk
    do_start(16'h5002);
    @(posedge i_clk);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_rd", o_rd, 0);
    check("arst_free", o_free, 0);
    check("arst_count", o_count, 0);
    check("arst_raddr", o_raddr, 16'h0000);
    check("arst_addr", o_addr, 16'h0000);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_start(16'h5000);
    watch(40, cyc, dn, fl_seen);
    check("post_rst_done", dn, 1);
    check("post_rst_count", o_count, 1);

`ifdef LIST_FREE_LIMIT_EN
    // Cyclic chain 5007 <-> 5008 stopped after MAX_CELLS=4 frees
    do_start(16'h5007);
    watch(60, cyc, dn, fl_seen);
    check("lim_fail", fl_seen, 1);
    check("lim_done", dn, 0);
    check("lim_count", o_count, 4);
    check("lim_cyc", cyc, 9);
    check("lim_nfree", tr_fr.size(), 4);
    check("lim_busy", o_busy, 0);
`endif

    check("rd_free_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
